tpu_job_sequencer: RTL and testbench

Host-side sequencer directly upstream of the TPU core (`tpuv1`). It drives the core's memory-mapped bus to run one complete matrix job:
- load A, load B, optionally load C;
- kick the multiply and wait it out;
- stream the 16 result words back out.

Operands enter on a valid/ready input stream and results leave on a valid/ready output stream, so the host never drives TPU addresses itself.

---
 rtl/tpu_pkg.sv | 27 ++
 rtl/tpu_job_sequencer_if.sv | 57 +++++
 rtl/tpu_job_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_tpu_job_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: address map, strides and state encoding
// shared by the TPU host-side job sequencer.
package tpu_pkg;

  localparam logic [15:0] A_BASE   = 16'h0100;
  localparam logic [15:0] B_BASE   = 16'h0200;
  localparam logic [15:0] C_BASE   = 16'h0300;
  localparam logic [15:0] MUL_ADDR = 16'h0400;

  localparam int AB_STRIDE    = 8;
  localparam int C_ROW_STRIDE = 16;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    C_LO,
    C_HI,
    C_WR_LO,
    C_WR_HI,
    MUL_KICK,
    MUL_WAIT,
    READ_C,
    DONE
  } seq_state_e;

endpackage

// File: rtl/tpu_job_sequencer_if.sv
// tpu_job_sequencer_if: job control, operand/result
// streams and TPU bus between host side and sequencer.
interface tpu_job_sequencer_if #(
  parameter int DATAW = 64,
  parameter int ADDRW = 16
);

  logic             start;
  logic             load_c;
  logic             busy;
  logic             done;
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [ADDRW-1:0] tpu_addr;
  logic             tpu_r_w;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (
    output start,
    output load_c,
    output in_data,
    output in_valid,
    output out_ready,
    output tpu_rdata,
    input  busy,
    input  done,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  tpu_addr,
    input  tpu_r_w,
    input  tpu_wdata
  );

  modport slave (
    input  start,
    input  load_c,
    input  in_data,
    input  in_valid,
    input  out_ready,
    input  tpu_rdata,
    output busy,
    output done,
    output in_ready,
    output out_data,
    output out_valid,
    output tpu_addr,
    output tpu_r_w,
    output tpu_wdata
  );

endinterface

// File: rtl/tpu_job_sequencer.sv
// tpu_job_sequencer: runs one matrix job on the TPU core
// (load A/B/[C], multiply, stream results out).
module tpu_job_sequencer
  import tpu_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int DATAW = 64,
  parameter int ADDRW = 16
) (
  input logic               clk,
  input logic               rst,
  tpu_job_sequencer_if.slave bus
);

  localparam int CW = $clog2(2*DIM) + 1;
  localparam int WW = $clog2(3*DIM) + 1;

  localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);
  localparam logic [CW-1:0] LAST_RD  = CW'(2*DIM - 1);
  localparam logic [CW-1:0] N_RD     = CW'(2*DIM);
  localparam logic [WW-1:0] LAST_WT  = WW'(3*DIM - 1);

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             load_c_q, load_c_d;
  logic [DATAW-1:0] lo_buf_q, lo_buf_d;
  logic [DATAW-1:0] hi_buf_q, hi_buf_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic             r_w_q, r_w_d;
  logic [DATAW-1:0] wdata_q, wdata_d;
  logic [DATAW-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             slot_free;

  function automatic logic [ADDRW-1:0] row_addr(
    input logic [15:0]   base,
    input logic [CW-1:0] k,
    input int            stride
  );
    return ADDRW'(base) + ADDRW'(k) * ADDRW'(stride);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      load_c_q    <= 1'b0;
      lo_buf_q    <= '0;
      hi_buf_q    <= '0;
      addr_q      <= '0;
      r_w_q       <= 1'b0;
      wdata_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      load_c_q    <= load_c_d;
      lo_buf_q    <= lo_buf_d;
      hi_buf_q    <= hi_buf_d;
      addr_q      <= addr_d;
      r_w_q       <= r_w_d;
      wdata_q     <= wdata_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    load_c_d    = load_c_q;
    lo_buf_d    = lo_buf_q;
    hi_buf_d    = hi_buf_q;
    addr_d      = '0;
    r_w_d       = 1'b0;
    wdata_d     = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    slot_free   = !out_valid_q || bus.out_ready;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = LOAD_A;
          load_c_d = bus.load_c;
          cnt_d    = '0;
        end
      end
      LOAD_A, LOAD_B: begin
        if (bus.in_valid) begin
          addr_d  = row_addr((state_q == LOAD_A) ? A_BASE : B_BASE,
                             cnt_q, AB_STRIDE);
          r_w_d   = 1'b1;
          wdata_d = bus.in_data;
          if (cnt_q == LAST_ROW) begin
            cnt_d = '0;
            if (state_q == LOAD_A) begin
              state_d = LOAD_B;
            end else begin
              state_d = load_c_q ? C_LO : MUL_KICK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      C_LO: begin
        if (bus.in_valid) begin
          lo_buf_d = bus.in_data;
          state_d  = C_HI;
        end
      end
      C_HI: begin
        if (bus.in_valid) begin
          hi_buf_d = bus.in_data;
          state_d  = C_WR_LO;
        end
      end
      // Both halves of a C row reach the core on adjacent cycles.
      C_WR_LO: begin
        addr_d  = row_addr(C_BASE, cnt_q, C_ROW_STRIDE);
        r_w_d   = 1'b1;
        wdata_d = lo_buf_q;
        state_d = C_WR_HI;
      end
      C_WR_HI: begin
        addr_d  = row_addr(C_BASE, cnt_q, C_ROW_STRIDE)
                + ADDRW'(AB_STRIDE);
        r_w_d   = 1'b1;
        wdata_d = hi_buf_q;
        if (cnt_q == LAST_ROW) begin
          cnt_d   = '0;
          state_d = MUL_KICK;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = C_LO;
        end
      end
      MUL_KICK: begin
        addr_d  = ADDRW'(MUL_ADDR);
        r_w_d   = 1'b1;
        wait_d  = '0;
        state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (wait_q == LAST_WT) begin
          state_d = READ_C;
          cnt_d   = '0;
          addr_d  = ADDRW'(C_BASE);
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      // cnt_q == N_RD means all reads issued; drain the last word.
      READ_C: begin
        if (cnt_q != N_RD) begin
          if (slot_free) begin
            out_data_d  = bus.tpu_rdata;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q != LAST_RD) begin
              addr_d = row_addr(C_BASE, cnt_q + 1'b1, AB_STRIDE);
            end
          end else begin
            addr_d = addr_q;
          end
        end else if (out_valid_q && bus.out_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B)
                 || (state_q == C_LO)   || (state_q == C_HI);
    bus.busy      = (state_q != IDLE) && (state_q != DONE);
    bus.done      = (state_q == DONE);
    bus.tpu_addr  = addr_q;
    bus.tpu_r_w   = r_w_q;
    bus.tpu_wdata = wdata_q;
    bus.out_data  = out_data_q;
    bus.out_valid = out_valid_q;
  end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// tb_tpu_job_sequencer: drives whole jobs through the
// sequencer and scores the bus and result streams.
module tb_tpu_job_sequencer;

  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tpu_job_sequencer_if #(.DATAW(64), .ADDRW(16)) bus ();

  tpu_job_sequencer #(
    .DIM  (8),
    .DATAW(64),
    .ADDRW(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Core stand-in: read data is the address itself.
  assign bus.tpu_rdata = {48'h0, bus.tpu_addr};

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] jw[$];
  int          jg[$];

  logic [15:0] t_addr[$];
  bit          t_rw[$];
  logic [63:0] t_wd[$];
  bit          t_busy[$];
  bit          t_done[$];
  bit          t_inr[$];
  bit          t_hs[$];
  logic [63:0] t_out[$];

  always @(negedge clk) begin
    t_addr.push_back(bus.tpu_addr);
    t_rw.push_back(bus.tpu_r_w);
    t_wd.push_back(bus.tpu_wdata);
    t_busy.push_back(bus.busy);
    t_done.push_back(bus.done);
    t_inr.push_back(bus.in_ready);
    t_hs.push_back(bus.out_valid && bus.out_ready);
    t_out.push_back(bus.out_data);
  end

  task automatic run_job(input bit lc, input bit rmode,
                         input bit stall3, input bit poke);
    int          b, e, m, d, last_hs, bad, ndone;
    logic [15:0] ea[$];
    logic [63:0] ed[$];
    int          wi[$];
    logic [15:0] rd[$];
    logic [63:0] ow[$];
    logic [63:0] want;
    @(posedge clk); #1;
    b = t_addr.size();
    bus.start  = 1'b1;
    bus.load_c = lc;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.load_c = ~lc;
    fork
      begin
        bit acc;
        bit to;
        int n;
        to = 1'b0;
        for (int i = 0; i < jw.size(); i++) begin
          repeat (jg[i]) begin
            bus.in_valid = 1'b0;
            bus.in_data  = {$urandom(), $urandom()};
            @(posedge clk); #1;
          end
          bus.in_valid = 1'b1;
          bus.in_data  = jw[i];
          n = 0;
          do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
          end while (!acc && n < LIMIT);
          if (!acc) to = 1'b1;
          if (to) break;
        end
        bus.in_valid = 1'b0;
      end
      begin
        int got, cyc, stl;
        bit fin, chk, once;
        got  = 0;
        cyc  = 0;
        stl  = 0;
        fin  = 1'b0;
        once = 1'b0;
        while (!fin && cyc < LIMIT) begin
          if (stl > 0) begin
            bus.out_ready = 1'b0;
            stl--;
            chk = 1'b1;
          end else begin
            bus.out_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
            chk = 1'b0;
          end
          if (poke) bus.start = (cyc == 40);
          @(negedge clk);
          if (chk) begin
            n_chk++;
            if (bus.out_data !== 64'h318 || bus.tpu_addr !== 16'h0320)
              $display("FAIL stall_hold: data %h addr %h, want 318 0320",
                       bus.out_data, bus.tpu_addr);
            else n_pass++;
          end
          if (bus.out_valid && bus.out_ready) got++;
          if (bus.done) fin = 1'b1;
          @(posedge clk); #1;
          cyc++;
          if (stall3 && !once && got == 3 && bus.out_valid) begin
            stl  = 4;
            once = 1'b1;
          end
        end
        bus.start = 1'b0;
        n_chk++;
        if (!fin) $display("FAIL job_done: no done within %0d cycles", LIMIT);
        else n_pass++;
      end
    join
    bus.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Expected write sequence from the address map.
    for (int k = 0; k < 8; k++) begin
      ea.push_back(16'h0100 + 16'(8*k));
      ed.push_back(jw[k]);
    end
    for (int k = 0; k < 8; k++) begin
      ea.push_back(16'h0200 + 16'(8*k));
      ed.push_back(jw[8+k]);
    end
    if (lc) begin
      for (int r = 0; r < 8; r++) begin
        ea.push_back(16'h0300 + 16'(16*r));
        ed.push_back(jw[16+2*r]);
        ea.push_back(16'h0308 + 16'(16*r));
        ed.push_back(jw[17+2*r]);
      end
    end
    ea.push_back(16'h0400);
    ed.push_back(64'h0);

    e       = t_addr.size();
    m       = -1;
    d       = -1;
    last_hs = -1;
    ndone   = 0;
    for (int i = b; i < e; i++) begin
      if (t_rw[i]) wi.push_back(i);
      if (t_hs[i]) begin
        ow.push_back(t_out[i]);
        last_hs = i;
      end
      if (t_done[i]) begin
        ndone++;
        d = i;
      end
    end

    n_chk++;
    if (wi.size() !== ea.size())
      $display("FAIL wr_count: got %0d, want %0d", wi.size(), ea.size());
    else n_pass++;
    for (int k = 0; k < ea.size() && k < wi.size(); k++) begin
      n_chk++;
      if (t_addr[wi[k]] !== ea[k] || t_wd[wi[k]] !== ed[k])
        $display("FAIL wr[%0d]: got %h/%h, want %h/%h", k,
                 t_addr[wi[k]], t_wd[wi[k]], ea[k], ed[k]);
      else n_pass++;
      if (t_addr[wi[k]] == 16'h0400) m = wi[k];
    end
    if (lc) begin
      for (int r = 0; r < 8; r++) begin
        n_chk++;
        if (wi.size() <= 17 + 2*r)
          $display("FAIL c_pair%0d: got missing write, want pair", r);
        else if (wi[17+2*r] - wi[16+2*r] != 1)
          $display("FAIL c_pair%0d: got gap %0d, want 1", r,
                   wi[17+2*r] - wi[16+2*r]);
        else n_pass++;
      end
    end

    n_chk++;
    if (m < 0 || m + 24 >= e) begin
      $display("FAIL mul_kick: got index %0d, want a kick write", m);
    end else begin
      n_pass++;
      bad = 0;
      for (int i = b; i < m; i++)
        if (!t_rw[i] && (t_addr[i] !== 16'h0 || t_wd[i] !== 64'h0)) bad++;
      n_chk++;
      if (bad != 0) $display("FAIL idle_load: got %0d bad cycles, want 0", bad);
      else n_pass++;
      bad = 0;
      for (int i = m + 1; i <= m + 23; i++)
        if (t_rw[i] || t_addr[i] !== 16'h0 || t_wd[i] !== 64'h0) bad++;
      n_chk++;
      if (bad != 0) $display("FAIL mul_wait: got %0d bad cycles, want 0", bad);
      else n_pass++;
      n_chk++;
      if (t_rw[m+24] || t_addr[m+24] !== 16'h0300)
        $display("FAIL first_read: got %h rw %0d, want 0300 rw 0",
                 t_addr[m+24], t_rw[m+24]);
      else n_pass++;
      for (int i = m + 1; i < e; i++)
        if (!t_rw[i] && t_addr[i] != 16'h0 &&
            (rd.size() == 0 || rd[$] != t_addr[i]))
          rd.push_back(t_addr[i]);
      n_chk++;
      if (rd.size() != 16)
        $display("FAIL rd_count: got %0d, want 16", rd.size());
      else n_pass++;
      for (int k = 0; k < 16 && k < rd.size(); k++) begin
        n_chk++;
        if (rd[k] !== 16'h0300 + 16'(8*k))
          $display("FAIL rd[%0d]: got %h, want %h", k, rd[k],
                   16'h0300 + 16'(8*k));
        else n_pass++;
      end
    end

    n_chk++;
    if (ow.size() != 16) $display("FAIL out_count: got %0d, want 16", ow.size());
    else n_pass++;
    for (int k = 0; k < 16 && k < ow.size(); k++) begin
      want = 64'h300 + 64'(8*k);
      n_chk++;
      if (ow[k] !== want)
        $display("FAIL out[%0d]: got %h, want %h", k, ow[k], want);
      else n_pass++;
    end

    n_chk++;
    if (ndone != 1 || d != last_hs + 1)
      $display("FAIL done_pulse: got %0d pulses at %0d, want 1 at %0d",
               ndone, d, last_hs + 1);
    else n_pass++;
    n_chk++;
    if (t_busy[b] !== 1'b0 || t_busy[b+1] !== 1'b1)
      $display("FAIL busy_rise: got %0d%0d, want 01", t_busy[b], t_busy[b+1]);
    else n_pass++;
    if (d > b) begin
      n_chk++;
      if (t_busy[d-1] !== 1'b1 || t_busy[d] !== 1'b0)
        $display("FAIL busy_fall: got %0d%0d, want 10",
                 t_busy[d-1], t_busy[d]);
      else n_pass++;
      bad = 0;
      for (int i = d; i < e; i++) if (t_busy[i] || t_inr[i]) bad++;
      n_chk++;
      if (bad != 0) $display("FAIL tail_idle: got %0d busy cycles, want 0", bad);
      else n_pass++;
    end
  endtask

  task automatic fill_seq(input bit lc, input logic [63:0] c0);
    jw.delete();
    jg.delete();
    for (int k = 0; k < 16; k++) begin
      jw.push_back(64'h11 + 64'(k));
      jg.push_back(0);
    end
    if (lc)
      for (int k = 0; k < 16; k++) begin
        jw.push_back(c0 + 64'(k));
        jg.push_back(0);
      end
  endtask

  task automatic fill_rand(input bit lc, input bit gaps);
    jw.delete();
    jg.delete();
    for (int k = 0; k < (lc ? 32 : 16); k++) begin
      jw.push_back({$urandom(), $urandom()});
      jg.push_back((gaps && $urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 3)) : 0);
    end
  endtask

  task automatic test_reset_state();
    logic [148:0] v;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.load_c    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    v = {bus.tpu_addr, bus.tpu_r_w, bus.tpu_wdata, bus.out_valid,
         bus.out_data, bus.busy, bus.done, bus.in_ready};
    n_chk++;
    if (v !== '0) $display("FAIL reset_state: got %h, want 0", v);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_no_c();
    fill_seq(1'b0, 64'h0);
    run_job(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_c();
    fill_seq(1'b1, 64'hC0);
    run_job(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_c_gap();
    fill_seq(1'b1, 64'hC0);
    jg[17] = 5;
    run_job(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_seq(1'b0, 64'h0);
    run_job(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    fill_rand(1'b1, 1'b0);
    run_job(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_start_with_rst();
    @(posedge clk); #1;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.load_c = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.start  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0)
        $display("FAIL start_rst: busy %0d in_ready %0d, want 0 0",
                 bus.busy, bus.in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_job();
    logic [148:0] v;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.load_c   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h51;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.in_data = 64'h60 + 64'(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.tpu_addr !== 16'h0210 || bus.tpu_r_w !== 1'b1 ||
        bus.tpu_wdata !== 64'h6A)
      $display("FAIL mid_b_write: got %h/%0d/%h, want 0210/1/6a",
               bus.tpu_addr, bus.tpu_r_w, bus.tpu_wdata);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        v = {bus.tpu_addr, bus.tpu_r_w, bus.tpu_wdata, bus.out_valid,
             bus.out_data, bus.busy, bus.done, bus.in_ready};
        n_chk++;
        if (v !== '0) $display("FAIL mid_reset: got %h, want 0", v);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL post_reset: in_ready %0d busy %0d, want 0 0",
               bus.in_ready, bus.busy);
    else n_pass++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    fill_rand(1'b0, 1'b0);
    run_job(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit lc;
    for (int j = 0; j < 4; j++) begin
      lc = 1'($urandom_range(0, 1));
      fill_rand(lc, 1'b1);
      run_job(lc, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset_state();
    test_no_c();
    test_load_c();
    test_c_gap();
    test_backpressure();
    test_start_while_busy();
    test_start_with_rst();
    test_reset_mid_job();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
